oram_mig_sequencer: RTL and testbench
=====================================

Name: oram_mig_sequencer

Overview:
- Downstream of the ORAM address generator; turns a stream of bucket base addresses into memory-controller (MIG) user-interface traffic.
- For each bucket it issues BURSTS_PER_BKT commands at strided addresses.
- For write-back buckets it also pushes the bucket's ciphertext beats into the MIG write FIFO ahead of each command.
- It asserts a completion pulse when the last bucket of a path has been fully issued.

Parameters:
- DRAM_ADDR_WIDTH, 30, MIG address width.
- DRAM_DATA_WIDTH, 128, MIG write-data beat width.
- BURSTS_PER_BKT, 4, MIG commands per bucket; must be at least 1.
- BURST_ADDR_STRIDE, 8, address increment between consecutive bursts of one bucket.
- BEATS_PER_BURST, 2, write-data beats per write burst; must be at least 1.

Ports:
- Clock  in  1  sole clock.
- Reset  in  1  asynchronous, active-low reset.
- BktAddr  in  DRAM_ADDR_WIDTH  bucket base address.
- BktIsWrite  in  1  1 = write-back bucket, 0 = read bucket.
- BktLast  in  1  marks the final bucket of the current path.
- BktValid  in  1  bucket descriptor valid.
- BktReady  out  1  descriptor accepted when BktValid & BktReady.
- WrDataIn  in  DRAM_DATA_WIDTH  ciphertext beat from the encrypt stage.
- WrDataInValid  in  1  beat valid.
- WrDataInReady  out  1  beat consumed when WrDataInValid & WrDataInReady.
- MIGRdy  in  1  MIG command accept.
- MIGEn  out  1  command valid.
- MIGInstr  out  3  3'b000 write, 3'b001 read.
- MIGAddr  out  DRAM_ADDR_WIDTH  command address.
- WrEn  out  1  write-FIFO push.
- WrData  out  DRAM_DATA_WIDTH  push data.
- WrDataEnd  out  1  last beat of a burst.
- WrFull  in  1  write FIFO full.
- PathDone  out  1  one-cycle pulse when a path is complete.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE, all counters 0.
  - BktReady=0 during reset.
  - MIGEn=0, MIGInstr=3'b001, MIGAddr=0.
  - WrEn=0, WrData=0, WrDataEnd=0, WrDataInReady=0, PathDone=0.
  - Reset mid-operation abandons the bucket; partially pushed beats are not retracted.
- States: IDLE, RCMD, WDATA, WCMD, DONE.
- IDLE:
  - BktReady=1.
  - On accept, latch BktAddr into AddrReg, latch IsWrite and Last, clear BurstCnt and BeatCnt.
  - Next state is WDATA if IsWrite, else RCMD.
- RCMD:
  - MIGEn=1, MIGInstr=3'b001, MIGAddr=AddrReg.
  - On MIGRdy: AddrReg += BURST_ADDR_STRIDE (modulo 2^DRAM_ADDR_WIDTH, wrap silently) and BurstCnt++.
  - If BurstCnt == BURSTS_PER_BKT-1, go to DONE if Last, else IDLE.
- WDATA:
  - WrDataInReady = ~WrFull.
  - WrEn = WrDataInValid & ~WrFull; WrData = WrDataIn (combinational pass-through).
  - WrDataEnd = WrEn & (BeatCnt == BEATS_PER_BURST-1).
  - On push, BeatCnt++. On the last beat, clear BeatCnt and go to WCMD.
  - WrFull stalls without losing the beat.
- WCMD:
  - MIGEn=1, MIGInstr=3'b000, MIGAddr=AddrReg.
  - On MIGRdy: advance AddrReg and BurstCnt.
  - If this was the last burst, go to DONE if Last, else IDLE; otherwise return to WDATA.
- DONE: PathDone=1 for exactly one cycle, then IDLE.
- Handshake rules:
  - While MIGEn=1 and MIGRdy=0, MIGAddr and MIGInstr are held stable.
  - MIGEn is never dropped before acceptance.
- Latency:
  - Descriptor accepted at cycle 0; first MIGEn or WrDataInReady at cycle 1.
  - With MIGRdy held high, a read bucket completes in BURSTS_PER_BKT cycles.
  - The next descriptor is accepted one cycle after the final command; BktReady=0 outside IDLE.
- Counter widths: BurstCnt and BeatCnt are clog2-sized, minimum 1 bit.

Decomposition:
- Package oram_mig_pkg holds:
  - MIG_CMD_WRITE=3'b000 and MIG_CMD_READ=3'b001;
  - the state encoding constants;
  - a clog2 function.
- No sub-module is needed; the burst counter and the beat counter are inline registers.

Test Plan:
- Read bucket: BktAddr=0x100, MIGRdy=1 → commands at 0x100, 0x108, 0x110, 0x118 with MIGInstr=001 on four consecutive cycles; BktReady=1 on the following cycle; PathDone stays 0.
- Write bucket, BktLast=1, data always valid:
  - 8 WrEn pushes, with WrDataEnd on beats 2, 4, 6, 8;
  - each write command follows its 2 beats;
  - addresses are 0x200, 0x208, 0x210, 0x218;
  - PathDone pulses once.
- WrFull asserted for 3 cycles in the middle of the first burst → WrEn=0 and WrDataInReady=0 while full; the held beat is pushed unchanged afterwards; total beat count is still 8.
- MIGRdy=0 for 5 cycles during a read → MIGEn and MIGAddr held stable; no command is skipped or duplicated.
- Wrap: BktAddr=0x3FFFFFF8 (30 bits) → addresses 0x3FFFFFF8, 0x0, 0x8, 0x10.
- Reset asserted during WCMD → all outputs reach reset values immediately; after release BktReady=1 and a new read bucket sequences correctly.

Source files
------------

// File: rtl/oram_mig_pkg.sv
// Shared constants for the ORAM MIG sequencer: command opcodes, FSM encoding, sizing helper.
// No logic here.
package oram_mig_pkg;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RCMD  = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_WCMD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/oram_mig_sequencer.sv
// Turns bucket descriptors into strided MIG commands, pushing write beats ahead of each write burst.
// First command/beat one cycle after accept; MIGRdy and WrFull stall in place with outputs held.
module oram_mig_sequencer
  import oram_mig_pkg::*;
#(
  parameter int DRAM_ADDR_WIDTH   = 30,
  parameter int DRAM_DATA_WIDTH   = 128,
  parameter int BURSTS_PER_BKT    = 4,
  parameter int BURST_ADDR_STRIDE = 8,
  parameter int BEATS_PER_BURST   = 2
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [DRAM_ADDR_WIDTH-1:0] BktAddr,
  input  logic                       BktIsWrite,
  input  logic                       BktLast,
  input  logic                       BktValid,
  output logic                       BktReady,
  input  logic [DRAM_DATA_WIDTH-1:0] WrDataIn,
  input  logic                       WrDataInValid,
  output logic                       WrDataInReady,
  input  logic                       MIGRdy,
  output logic                       MIGEn,
  output logic [2:0]                 MIGInstr,
  output logic [DRAM_ADDR_WIDTH-1:0] MIGAddr,
  output logic                       WrEn,
  output logic [DRAM_DATA_WIDTH-1:0] WrData,
  output logic                       WrDataEnd,
  input  logic                       WrFull,
  output logic                       PathDone
);

  localparam int BurstCntW = (clog2(BURSTS_PER_BKT) > 1) ? clog2(BURSTS_PER_BKT) : 1;
  localparam int BeatCntW  = (clog2(BEATS_PER_BURST) > 1) ? clog2(BEATS_PER_BURST) : 1;
  localparam logic [DRAM_ADDR_WIDTH-1:0] AddrStride = DRAM_ADDR_WIDTH'(BURST_ADDR_STRIDE);

  logic [2:0]                 state;
  logic [DRAM_ADDR_WIDTH-1:0] addrReg;
  logic                       isWrite;
  logic                       isLast;
  logic [BurstCntW-1:0]       burstCnt;
  logic [BeatCntW-1:0]        beatCnt;

  logic inCmd;
  logic inData;
  logic lastBurst;
  logic lastBeat;
  logic wrPush;

  assign inCmd     = (state == ST_RCMD) || (state == ST_WCMD);
  assign inData    = (state == ST_WDATA);
  assign lastBurst = (burstCnt == BurstCntW'(BURSTS_PER_BKT - 1));
  assign lastBeat  = (beatCnt == BeatCntW'(BEATS_PER_BURST - 1));
  assign wrPush    = inData & WrDataInValid & ~WrFull;

  // Gated by Reset so the upstream never sees a ready while the block is held in reset.
  assign BktReady      = Reset & (state == ST_IDLE);
  assign MIGEn         = inCmd;
  assign MIGInstr      = (state == ST_WCMD) ? MIG_CMD_WRITE : MIG_CMD_READ;
  assign MIGAddr       = addrReg;
  assign WrDataInReady = inData & ~WrFull;
  assign WrEn          = wrPush;
  assign WrData        = inData ? WrDataIn : '0;
  assign WrDataEnd     = wrPush & lastBeat;
  assign PathDone      = (state == ST_DONE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      addrReg  <= '0;
      isWrite  <= 1'b0;
      isLast   <= 1'b0;
      burstCnt <= '0;
      beatCnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (BktValid) begin
            addrReg  <= BktAddr;
            isWrite  <= BktIsWrite;
            isLast   <= BktLast;
            burstCnt <= '0;
            beatCnt  <= '0;
            state    <= BktIsWrite ? ST_WDATA : ST_RCMD;
          end
        end
        ST_RCMD, ST_WCMD: begin
          if (MIGRdy) begin
            addrReg  <= addrReg + AddrStride;
            burstCnt <= burstCnt + BurstCntW'(1);
            if (lastBurst) state <= isLast ? ST_DONE : ST_IDLE;
            else           state <= isWrite ? ST_WDATA : ST_RCMD;
          end
        end
        ST_WDATA: begin
          if (wrPush) begin
            if (lastBeat) begin
              beatCnt <= '0;
              state   <= ST_WCMD;
            end else begin
              beatCnt <= beatCnt + BeatCntW'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oram_mig_sequencer.sv
// Self-checking bench for oram_mig_sequencer: directed scenarios plus randomized buckets
// checked against a transaction-level model of expected commands, beats and completion.
module tb_oram_mig_sequencer;

  localparam int AW  = 30;
  localparam int DW  = 128;
  localparam int NB  = 4;
  localparam int STR = 8;
  localparam int BPB = 2;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic [AW-1:0] BktAddr = '0;
  logic          BktIsWrite = 1'b0;
  logic          BktLast = 1'b0;
  logic          BktValid = 1'b0;
  logic          BktReady;
  logic [DW-1:0] WrDataIn = '0;
  logic          WrDataInValid = 1'b0;
  logic          WrDataInReady;
  logic          MIGRdy = 1'b0;
  logic          MIGEn;
  logic [2:0]    MIGInstr;
  logic [AW-1:0] MIGAddr;
  logic          WrEn;
  logic [DW-1:0] WrData;
  logic          WrDataEnd;
  logic          WrFull = 1'b0;
  logic          PathDone;

  int checks = 0;
  int passed = 0;

  oram_mig_sequencer #(
    .DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW), .BURSTS_PER_BKT(NB),
    .BURST_ADDR_STRIDE(STR), .BEATS_PER_BURST(BPB)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .BktAddr(BktAddr), .BktIsWrite(BktIsWrite), .BktLast(BktLast),
    .BktValid(BktValid), .BktReady(BktReady),
    .WrDataIn(WrDataIn), .WrDataInValid(WrDataInValid), .WrDataInReady(WrDataInReady),
    .MIGRdy(MIGRdy), .MIGEn(MIGEn), .MIGInstr(MIGInstr), .MIGAddr(MIGAddr),
    .WrEn(WrEn), .WrData(WrData), .WrDataEnd(WrDataEnd), .WrFull(WrFull),
    .PathDone(PathDone)
  );

  always #5 Clock = ~Clock;

  // Sends one bucket and watches it through to the return of BktReady.
  // stallAt/fullAt force MIGRdy low / WrFull high over a cycle window (cycle 1 = first after accept).
  task automatic run_bucket(input logic [AW-1:0] base, input logic wr, input logic last,
                            input int rdyPct, input int validPct, input int fullPct,
                            input int stallAt, input int stallLen,
                            input int fullAt, input int fullLen,
                            input string tag, output int doneCycle);
    logic [DW-1:0] src[$];
    logic [AW-1:0] expAddr;
    logic [2:0]    expInstr;
    logic [2:0]    heldInstr;
    logic [AW-1:0] heldAddr;
    logic          pendHold;
    logic          finished;
    int cmdN, beatN, doneN, holdErr, fullErr, srcIdx, cyc, w;
    cmdN = 0; beatN = 0; doneN = 0; holdErr = 0; fullErr = 0; srcIdx = 0; cyc = 0;
    pendHold = 1'b0; finished = 1'b0; heldInstr = '0; heldAddr = '0;
    expInstr = wr ? 3'b000 : 3'b001;
    doneCycle = -1;
    for (int i = 0; i < NB * BPB; i++) src.push_back({$urandom(), $urandom(), $urandom(), $urandom()});

    @(posedge Clock); #1;
    BktAddr = base; BktIsWrite = wr; BktLast = last; BktValid = 1'b1;
    MIGRdy = 1'b0; WrFull = 1'b0; WrDataInValid = 1'b0;
    w = 0;
    @(negedge Clock);
    while (!BktReady && w < 50) begin @(negedge Clock); w++; end
    checks++;
    if (!BktReady) $display("FAIL %s accept: BktReady=%0b required 1", tag, BktReady);
    else passed++;

    while (cyc < 300 && !finished) begin
      @(posedge Clock); #1;
      cyc++;
      BktValid = 1'b0;
      MIGRdy = ($urandom_range(99) < rdyPct) &&
               !(stallAt >= 0 && cyc >= stallAt && cyc < stallAt + stallLen);
      WrFull = ($urandom_range(99) < fullPct) ||
               (fullAt >= 0 && cyc >= fullAt && cyc < fullAt + fullLen);
      WrDataInValid = (srcIdx < src.size()) && ($urandom_range(99) < validPct);
      WrDataIn = (srcIdx < src.size()) ? src[srcIdx] : {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge Clock);
      if (BktReady) begin
        finished = 1'b1;
        doneCycle = cyc;
      end else begin
        if (pendHold && (!MIGEn || MIGAddr !== heldAddr || MIGInstr !== heldInstr)) holdErr++;
        pendHold = MIGEn && !MIGRdy;
        heldAddr = MIGAddr;
        heldInstr = MIGInstr;
        if (WrFull && (WrEn || WrDataInReady)) fullErr++;
        if (PathDone) doneN++;
        if (WrEn) begin
          checks++;
          if (beatN >= src.size() || WrData !== src[beatN] || WrDataEnd !== ((beatN % BPB) == BPB - 1))
            $display("FAIL %s beat%0d: data=%h end=%0b required data=%h end=%0b", tag, beatN, WrData,
                     WrDataEnd, (beatN < src.size()) ? src[beatN] : '0, (beatN % BPB) == BPB - 1);
          else passed++;
          beatN++;
        end
        if (WrDataInValid && WrDataInReady) srcIdx++;
        if (MIGEn && MIGRdy) begin
          expAddr = base + AW'(cmdN * STR);
          checks++;
          if (MIGInstr !== expInstr || MIGAddr !== expAddr || (wr && beatN != (cmdN + 1) * BPB))
            $display("FAIL %s cmd%0d: instr=%b addr=%h beatsBefore=%0d required instr=%b addr=%h beatsBefore=%0d",
                     tag, cmdN, MIGInstr, MIGAddr, beatN, expInstr, expAddr, wr ? (cmdN + 1) * BPB : 0);
          else passed++;
          cmdN++;
        end
      end
    end

    checks++;
    if (!finished) $display("FAIL %s timeout: BktReady not back after %0d cycles, required within 300", tag, cyc);
    else passed++;
    checks++;
    if (cmdN != NB) $display("FAIL %s cmdCount: %0d required %0d", tag, cmdN, NB);
    else passed++;
    checks++;
    if (beatN != (wr ? NB * BPB : 0)) $display("FAIL %s beatCount: %0d required %0d", tag, beatN, wr ? NB * BPB : 0);
    else passed++;
    checks++;
    if (doneN != int'(last)) $display("FAIL %s pathDone: %0d pulses required %0d", tag, doneN, int'(last));
    else passed++;
    checks++;
    if (holdErr != 0 || fullErr != 0)
      $display("FAIL %s stall: holdErr=%0d fullErr=%0d required 0/0", tag, holdErr, fullErr);
    else passed++;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    BktValid = 1'b1; BktAddr = 30'h155; WrDataInValid = 1'b1; WrDataIn = {4{32'hdeadbeef}};
    MIGRdy = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checks++;
    if (BktReady !== 1'b0) $display("FAIL reset BktReady: %b required 0", BktReady); else passed++;
    checks++;
    if (MIGEn !== 1'b0 || MIGInstr !== 3'b001 || MIGAddr !== '0)
      $display("FAIL reset mig: en=%b instr=%b addr=%h required 0/001/0", MIGEn, MIGInstr, MIGAddr);
    else passed++;
    checks++;
    if (WrEn !== 1'b0 || WrData !== '0 || WrDataEnd !== 1'b0 || WrDataInReady !== 1'b0 || PathDone !== 1'b0)
      $display("FAIL reset wr: en=%b data=%h end=%b inRdy=%b done=%b required all 0",
               WrEn, WrData, WrDataEnd, WrDataInReady, PathDone);
    else passed++;
    BktValid = 1'b0; WrDataInValid = 1'b0; MIGRdy = 1'b0;
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if (BktReady !== 1'b1) $display("FAIL reset release BktReady: %b required 1", BktReady); else passed++;
  endtask

  task automatic test_read();
    int dc;
    run_bucket(30'h100, 1'b0, 1'b0, 100, 100, 0, -1, 0, -1, 0, "read", dc);
    checks++;
    if (dc != NB + 1) $display("FAIL read latency: ready at cycle %0d required %0d", dc, NB + 1); else passed++;
  endtask

  task automatic test_write();
    int dc;
    run_bucket(30'h200, 1'b1, 1'b1, 100, 100, 0, -1, 0, -1, 0, "write", dc);
    checks++;
    if (dc != NB * (BPB + 1) + 2) $display("FAIL write latency: ready at cycle %0d required %0d", dc, NB * (BPB + 1) + 2);
    else passed++;
  endtask

  task automatic test_wrfull();
    int dc;
    run_bucket(30'h300, 1'b1, 1'b0, 100, 100, 0, -1, 0, 2, 3, "wrfull", dc);
    checks++;
    if (dc != NB * (BPB + 1) + 1 + 3) $display("FAIL wrfull latency: ready at cycle %0d required %0d", dc, NB * (BPB + 1) + 4);
    else passed++;
  endtask

  task automatic test_mig_stall();
    int dc;
    run_bucket(30'h480, 1'b0, 1'b0, 100, 100, 0, 2, 5, -1, 0, "migstall", dc);
    checks++;
    if (dc != NB + 1 + 5) $display("FAIL migstall latency: ready at cycle %0d required %0d", dc, NB + 6); else passed++;
  endtask

  task automatic test_wrap();
    int dc;
    run_bucket(30'h3FFFFFF8, 1'b0, 1'b1, 100, 100, 0, -1, 0, -1, 0, "wrap", dc);
  endtask

  task automatic test_reset_mid();
    int w, dc;
    logic seen;
    @(posedge Clock); #1;
    BktAddr = 30'h400; BktIsWrite = 1'b1; BktLast = 1'b0; BktValid = 1'b1;
    MIGRdy = 1'b0; WrFull = 1'b0; WrDataInValid = 1'b1; WrDataIn = {4{32'h0badf00d}};
    seen = 1'b0; w = 0;
    while (!seen && w < 20) begin
      @(posedge Clock); #1;
      BktValid = 1'b0;
      @(negedge Clock);
      seen = MIGEn && (MIGInstr == 3'b000);
      w++;
    end
    checks++;
    if (!seen) $display("FAIL midreset wcmd: MIGEn=%b instr=%b required 1/000", MIGEn, MIGInstr); else passed++;
    #2 Reset = 1'b0;
    #1;
    checks++;
    if ({BktReady, MIGEn, MIGInstr, MIGAddr, WrEn, WrDataEnd, WrDataInReady, PathDone} !== {1'b0, 1'b0, 3'b001, 30'h0, 4'b0000}
        || WrData !== '0)
      $display("FAIL midreset outputs: rdy=%b en=%b instr=%b addr=%h wrEn=%b end=%b inRdy=%b done=%b data=%h required 0/0/001/0/0/0/0/0/0",
               BktReady, MIGEn, MIGInstr, MIGAddr, WrEn, WrDataEnd, WrDataInReady, PathDone, WrData);
    else passed++;
    @(posedge Clock); #1;
    Reset = 1'b1; WrDataInValid = 1'b0;
    @(negedge Clock);
    checks++;
    if (BktReady !== 1'b1) $display("FAIL midreset release BktReady: %b required 1", BktReady); else passed++;
    run_bucket(30'h500, 1'b0, 1'b0, 100, 100, 0, -1, 0, -1, 0, "postreset", dc);
  endtask

  task automatic test_random();
    int dc;
    for (int i = 0; i < 20; i++) begin
      run_bucket(AW'($urandom()), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 $urandom_range(100, 30), $urandom_range(100, 40), $urandom_range(40),
                 -1, 0, -1, 0, $sformatf("rand%0d", i), dc);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_wrfull();
    test_mig_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
